// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V main controller: opcodes, state
// encodings, datapath select encodings and the packed control word.
package riscv_ctrl_pkg;

  // Supported major opcodes (instr[6:0])
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // funct7 value that marks an M-extension multiply
  localparam logic [6:0] Funct7Mul = 7'b0000001;

  // Controller states; numeric values are visible on the debug State port
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StMulWait  = 4'd11
  } state_e;

  // ALU_Op codes consumed by the ALU decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpItype = 2'b11;

  // ResultSrc selects
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // ALUSrcA selects
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // Moore control word produced from the state alone
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control word decode. Kept separate so a pipelined
// control path can reuse the same per-state datapath settings.
// MUL_WAIT_EN: when defined, MULWAIT repeats the EXECR control word.
module ctrl_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t ctrl_o
);

  // Per-state Moore outputs; anything not set stays 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.alu_src_a  = SrcAPc;
        ctrl_o.alu_src_b  = SrcBFour;
        ctrl_o.alu_op     = AluOpAdd;
        ctrl_o.result_src = ResAluResult;
        ctrl_o.pc_update  = 1'b1;
      end
      StDecode: begin
        // Branch target precompute: OldPC + imm
        ctrl_o.alu_src_a = SrcAOldPc;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = ResAluOut;
      end
      StMemWb: begin
        ctrl_o.result_src = ResMemData;
        ctrl_o.reg_write  = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = ResAluOut;
        ctrl_o.mem_write  = 1'b1;
      end
`ifdef MUL_WAIT_EN
      StExecR, StMulWait: begin
`else
      StExecR: begin
`endif
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBRs2;
        ctrl_o.alu_op    = AluOpRtype;
      end
      StExecI: begin
        ctrl_o.alu_src_a = SrcARs1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpItype;
      end
      StAluWb: begin
        ctrl_o.result_src = ResAluOut;
        ctrl_o.reg_write  = 1'b1;
      end
      StBeq: begin
        ctrl_o.alu_src_a  = SrcARs1;
        ctrl_o.alu_src_b  = SrcBRs2;
        ctrl_o.alu_op     = AluOpSub;
        ctrl_o.result_src = ResAluOut;
        ctrl_o.branch     = 1'b1;
      end
      StJal: begin
        // PC <= branch target from DECODE; ALU computes OldPC + 4 for rd
        ctrl_o.alu_src_a  = SrcAOldPc;
        ctrl_o.alu_src_b  = SrcBFour;
        ctrl_o.alu_op     = AluOpAdd;
        ctrl_o.result_src = ResAluOut;
        ctrl_o.pc_update  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main controller. Sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath enables.
// MUL_WAIT_EN: when defined, mul (funct7=0000001) holds EXECR settings for
// MUL_LATENCY cycles via the MULWAIT state; otherwise mul takes one cycle.
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [6:0] Funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_Op,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  ctrl_word_t ctrl;
  logic       illegal;

`ifdef MUL_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  // Remaining MULWAIT cycles after the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [6:0]  unused_funct7;
  logic [31:0] unused_mul_latency;
  assign unused_funct7      = Funct7;
  assign unused_mul_latency = 32'(MUL_LATENCY);
`endif

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the DECODE-time illegal-opcode flag
  always_comb begin
    state_d = StFetch;
    illegal = 1'b0;
`ifdef MUL_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default: begin
            // PC already advanced in FETCH, so skipping acts as a NOP
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr:   state_d = (Opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR: begin
        state_d = StAluWb;
`ifdef MUL_WAIT_EN
        if (Funct7 == Funct7Mul && MUL_LATENCY > 1) begin
          state_d = StMulWait;
          cnt_d   = 4'(MUL_LATENCY - 2);
        end
`endif
      end
`ifdef MUL_WAIT_EN
      StMulWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAluWb;
        end else begin
          state_d = StMulWait;
          cnt_d   = cnt_q - 4'd1;
        end
      end
`endif
      StExecI: state_d = StAluWb;
      StAluWb: state_d = StFetch;
      StJal:   state_d = StAluWb;
      StBeq:   state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  ctrl_output_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Outputs are forced low while reset is held, even though state reads FETCH
  always_comb begin
    PCWrite   = ~rst & (ctrl.pc_update | (ctrl.branch & Zero));
    AdrSrc    = ~rst & ctrl.adr_src;
    MemWrite  = ~rst & ctrl.mem_write;
    IRWrite   = ~rst & ctrl.ir_write;
    RegWrite  = ~rst & ctrl.reg_write;
    ResultSrc = rst ? 2'b00 : ctrl.result_src;
    ALUSrcA   = rst ? 2'b00 : ctrl.alu_src_a;
    ALUSrcB   = rst ? 2'b00 : ctrl.alu_src_b;
    ALU_Op    = rst ? 2'b00 : ctrl.alu_op;
    IllegalOp = ~rst & illegal;
    State     = state_q;
  end

endmodule
